// File: rtl/control_unit_if.sv
// ---------------------------------------------------------------------------
// control_unit_if
//    Bundles the signals between the hardwired control unit and the
//    datapath.
//    Datapath to control:
//       IR    instruction register contents, where IR[31:27] is the opcode.
//       Stop  external halt request.
//    Control to datapath:
//       Bus-drive strobes:       PCout, Zhighout, Zlowout, MDRout, HIout, LOout.
//       Register-load strobes:   PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin.
//       PC and memory:           IncPC, Read, Write.
//       Select-and-encode:       Gra, Grb, Grc, Rin, Rout, BAout, Cout.
//       ALU operation:           opcode.
//       Run                      low only while halted.
//       Present_state            current state, for debug.
//    Modports:
//       master  the control unit.
//       slave   the datapath, or a testbench standing in for it.
// ---------------------------------------------------------------------------
interface control_unit_if;
   logic [31:0] IR;
   logic        Stop;
   logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
   logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
   logic        IncPC, Read, Write;
   logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
   logic [4:0]  opcode;
   logic        Run;
   logic [3:0]  Present_state;

   modport master (
      input  IR, Stop,
      output PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
      output PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
      output IncPC, Read, Write,
      output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
      output opcode, Run, Present_state
   );

   modport slave (
      output IR, Stop,
      input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
      input  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
      input  IncPC, Read, Write,
      input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
      input  opcode, Run, Present_state
   );
endinterface

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//    Hardwired Moore control unit for the 32-bit RISC datapath.
//    Every instruction is fetched in T0 to T2. It then executes in T3 to T7,
//    using only as many of those states as it needs.
//    Ports:
//       Clock  rising-edge system clock.
//       clear  synchronous, active-high reset.
//       bus    control_unit_if.master, carrying IR and Stop in and every
//              strobe out.
//    Present_state encoding:
//       RESET=0, T0..T7=1..8, HALT=9.
// ---------------------------------------------------------------------------
module control_unit (
   input  logic           Clock,
   input  logic           clear,
   control_unit_if.master bus
);
   typedef enum logic [3:0] {
      RESET = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
      T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, HALT = 4'd9
   } state_t;

   localparam logic [4:0] OP_LD  = 5'b00000, OP_LDI = 5'b00001, OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR  = 5'b00110, OP_SHR = 5'b00111, OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL = 5'b01001, OP_ROR = 5'b01010, OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110;
   localparam logic [4:0] OP_MUL = 5'b01111, OP_DIV = 5'b10000, OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT = 5'b10010, OP_MFHI = 5'b11000, OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_HALT = 5'b11011;

   state_t     state, next_state;
   logic [4:0] op_reg;
   logic [4:0] live_op;

   // Only the opcode field of IR is decoded here.
   logic unused_ir;
   assign unused_ir = ^bus.IR[26:0];
   assign live_op   = bus.IR[31:27];

   // Returns the final state of each instruction class.
   // Opcodes with no execute phase (nop, halt and unused encodings) end in T2.
   function automatic state_t last_state(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
         OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: last_state = T5;
         OP_NEG, OP_NOT:                   last_state = T4;
         OP_MUL, OP_DIV:                   last_state = T6;
         OP_LD, OP_ST:                     last_state = T7;
         OP_MFHI, OP_MFLO:                 last_state = T3;
         default:                          last_state = T2;
      endcase
   endfunction

   // State register.
   // The opcode is latched on the edge leaving T2, so that the execute
   // states never observe later changes on IR.
   always_ff @(posedge Clock) begin
      if (clear) begin
         state  <= RESET;
         op_reg <= 5'b00000;
      end else begin
         state <= next_state;
         if (state == T2)
            op_reg <= live_op;
      end
   end

   // Next-state logic.
   // In T2 the op register is not loaded yet, so the live opcode decides
   // between nop, halt and entering execute. Stop is honoured only on the
   // final state of an instruction.
   always_comb begin
      next_state = state;
      case (state)
         RESET: next_state = T0;
         T0:    next_state = T1;
         T1:    next_state = T2;
         T2: begin
            if (live_op == OP_HALT)
               next_state = HALT;
            else if (last_state(live_op) == T2)
               next_state = bus.Stop ? HALT : T0;
            else
               next_state = T3;
         end
         T3, T4, T5, T6, T7: begin
            if (state == last_state(op_reg))
               next_state = bus.Stop ? HALT : T0;
            else
               next_state = state_t'(state + 4'd1);
         end
         HALT:    next_state = HALT;
         default: next_state = RESET;
      endcase
   end

   // Output decode: a Moore function of the state and the latched opcode.
   // Every strobe defaults to 0, and each state raises only its own set.
   always_comb begin
      bus.PCout = 1'b0; bus.Zhighout = 1'b0; bus.Zlowout = 1'b0;
      bus.MDRout = 1'b0; bus.HIout = 1'b0; bus.LOout = 1'b0;
      bus.PCin = 1'b0; bus.MARin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0;
      bus.Yin = 1'b0; bus.Zin = 1'b0; bus.HIin = 1'b0; bus.LOin = 1'b0;
      bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
      bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0;
      bus.Rout = 1'b0; bus.BAout = 1'b0; bus.Cout = 1'b0;
      bus.opcode = 5'b00000;
      bus.Run = (state != HALT);
      bus.Present_state = state;
      case (state)
         T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
         T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
         T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
         T3: case (op_reg)
            OP_LD, OP_LDI, OP_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
            OP_ADDI, OP_ANDI, OP_ORI: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
            OP_NEG, OP_NOT: begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.opcode = op_reg; bus.Zin = 1'b1;
            end
            OP_MUL, OP_DIV: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
            OP_MFHI: begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_MFLO: begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            default: ;
         endcase
         T4: case (op_reg)
            OP_LD, OP_LDI, OP_ST, OP_ADDI: begin bus.Cout = 1'b1; bus.opcode = OP_ADD; bus.Zin = 1'b1; end
            OP_ANDI: begin bus.Cout = 1'b1; bus.opcode = OP_AND; bus.Zin = 1'b1; end
            OP_ORI:  begin bus.Cout = 1'b1; bus.opcode = OP_OR;  bus.Zin = 1'b1; end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
               bus.Grc = 1'b1; bus.Rout = 1'b1; bus.opcode = op_reg; bus.Zin = 1'b1;
            end
            OP_NEG, OP_NOT: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_MUL, OP_DIV: begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.opcode = op_reg; bus.Zin = 1'b1;
            end
            default: ;
         endcase
         T5: case (op_reg)
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
            OP_ADDI, OP_ANDI, OP_ORI: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_LD, OP_ST:   begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
            OP_MUL, OP_DIV: begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
            default: ;
         endcase
         T6: case (op_reg)
            OP_LD:          begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
            OP_ST:          begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
            OP_MUL, OP_DIV: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
            default: ;
         endcase
         T7: case (op_reg)
            OP_LD:   begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            OP_ST:   bus.Write = 1'b1;
            default: ;
         endcase
         default: ;
      endcase
   end
endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//    Self-checking bench for control_unit.
//    The stimulus process expands each opcode into its list of micro-steps
//    and queues one expected cycle at a time. An independent monitor pops
//    that queue on every falling edge and compares the state, strobes,
//    ALU opcode and Run against it.
// ---------------------------------------------------------------------------
module tb_control_unit;
   localparam logic [3:0] S_RESET = 4'd0, S_HALT = 4'd9;

   localparam logic [31:0] M_PCOUT = 32'd1 << 0,  M_ZHIGHOUT = 32'd1 << 1;
   localparam logic [31:0] M_ZLOWOUT = 32'd1 << 2, M_MDROUT = 32'd1 << 3;
   localparam logic [31:0] M_HIOUT = 32'd1 << 4,  M_LOOUT = 32'd1 << 5;
   localparam logic [31:0] M_PCIN = 32'd1 << 6,   M_MARIN = 32'd1 << 7;
   localparam logic [31:0] M_MDRIN = 32'd1 << 8,  M_IRIN = 32'd1 << 9;
   localparam logic [31:0] M_YIN = 32'd1 << 10,   M_ZIN = 32'd1 << 11;
   localparam logic [31:0] M_HIIN = 32'd1 << 12,  M_LOIN = 32'd1 << 13;
   localparam logic [31:0] M_INCPC = 32'd1 << 14, M_READ = 32'd1 << 15;
   localparam logic [31:0] M_WRITE = 32'd1 << 16, M_GRA = 32'd1 << 17;
   localparam logic [31:0] M_GRB = 32'd1 << 18,   M_GRC = 32'd1 << 19;
   localparam logic [31:0] M_RIN = 32'd1 << 20,   M_ROUT = 32'd1 << 21;
   localparam logic [31:0] M_BAOUT = 32'd1 << 22, M_COUT = 32'd1 << 23;

   typedef struct {
      logic [3:0]  state;
      logic [31:0] mask;
      logic [4:0]  alu;
      logic        run;
   } exp_t;

   typedef struct {
      logic [31:0] mask;
      logic [4:0]  alu;
   } step_t;

   logic   Clock = 1'b0;
   logic   clear;
   exp_t   expQ[$];
   step_t  stepQ[$];
   bit     stepHalt;
   int     checks = 0;
   int     failures = 0;

   control_unit_if bus();

   control_unit dut (
      .Clock (Clock),
      .clear (clear),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   // Comparison helper; every call counts as one check.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: expands an opcode into its fetch and execute
   // micro-steps, directly from the register-transfer table.
   task automatic addStep(input logic [31:0] m, input logic [4:0] a);
      step_t s;
      s.mask = m;
      s.alu = a;
      stepQ.push_back(s);
   endtask

   task automatic buildSteps(input logic [4:0] op);
      stepQ.delete();
      stepHalt = 0;
      addStep(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0);
      addStep(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0);
      addStep(M_MDROUT | M_IRIN, 5'd0);
      if (op >= 5'd3 && op <= 5'd11) begin
         addStep(M_GRB | M_ROUT | M_YIN, 5'd0);
         addStep(M_GRC | M_ROUT | M_ZIN, op);
         addStep(M_ZLOWOUT | M_GRA | M_RIN, 5'd0);
      end else if (op == 5'd17 || op == 5'd18) begin
         addStep(M_GRB | M_ROUT | M_ZIN, op);
         addStep(M_ZLOWOUT | M_GRA | M_RIN, 5'd0);
      end else if (op >= 5'd12 && op <= 5'd14) begin
         addStep(M_GRB | M_ROUT | M_YIN, 5'd0);
         addStep(M_COUT | M_ZIN, (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6);
         addStep(M_ZLOWOUT | M_GRA | M_RIN, 5'd0);
      end else if (op == 5'd15 || op == 5'd16) begin
         addStep(M_GRA | M_ROUT | M_YIN, 5'd0);
         addStep(M_GRB | M_ROUT | M_ZIN, op);
         addStep(M_ZLOWOUT | M_LOIN, 5'd0);
         addStep(M_ZHIGHOUT | M_HIIN, 5'd0);
      end else if (op <= 5'd2) begin
         addStep(M_GRB | M_BAOUT | M_YIN, 5'd0);
         addStep(M_COUT | M_ZIN, 5'd3);
         if (op == 5'd1)
            addStep(M_ZLOWOUT | M_GRA | M_RIN, 5'd0);
         else begin
            addStep(M_ZLOWOUT | M_MARIN, 5'd0);
            if (op == 5'd0) begin
               addStep(M_READ | M_MDRIN, 5'd0);
               addStep(M_MDROUT | M_GRA | M_RIN, 5'd0);
            end else begin
               addStep(M_GRA | M_ROUT | M_MDRIN, 5'd0);
               addStep(M_WRITE, 5'd0);
            end
         end
      end else if (op == 5'd24)
         addStep(M_HIOUT | M_GRA | M_RIN, 5'd0);
      else if (op == 5'd25)
         addStep(M_LOOUT | M_GRA | M_RIN, 5'd0);
      else if (op == 5'd27)
         stepHalt = 1;
   endtask

   // One cycle: queue the expectation for the state that is now presented,
   // then drive the inputs that the next rising edge will sample.
   task automatic applyStimulus(input logic [3:0] st, input logic [31:0] m, input logic [4:0] a,
                                input logic run, input logic clr, input logic stp, input logic [31:0] ir);
      exp_t e;
      e.state = st;
      e.mask = m;
      e.alu = a;
      e.run = run;
      expQ.push_back(e);
      clear = clr;
      bus.Stop = stp;
      bus.IR = ir;
      @(posedge Clock);
      #1;
   endtask

   task automatic haltStay(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(S_HALT, 32'd0, 5'd0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom);
      applyStimulus(S_HALT, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, $urandom);
      applyStimulus(S_RESET, 32'd0, 5'd0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom);
   endtask

   // Runs one instruction from T0. abortAt asserts clear in that step
   // (-1 means never, -2 means pick at random now and then).
   task automatic runInstr(input logic [4:0] op, input bit stopEnd, input int abortAt);
      int abortStep;
      int last;
      logic [31:0] ir;
      logic stp;
      buildSteps(op);
      last = stepQ.size() - 1;
      abortStep = abortAt;
      if (abortAt == -2)
         abortStep = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, last)) : -1;
      for (int k = 0; k <= last; k++) begin
         ir = $urandom;
         if (k == 2)
            ir[31:27] = op;
         stp = 1'($urandom_range(0, 1));
         if (k == last)
            stp = stopEnd;
         applyStimulus(4'(k + 1), stepQ[k].mask, stepQ[k].alu, 1'b1, (k == abortStep), stp, ir);
         if (k == abortStep) begin
            applyStimulus(S_RESET, 32'd0, 5'd0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom);
            return;
         end
      end
      if (stepHalt || stopEnd)
         haltStay(stepHalt ? 10 : int'($urandom_range(1, 4)));
   endtask

   // Monitor: compares one queued expectation against the outputs on every
   // falling edge, well away from the edge on which the strobes change.
   always @(negedge Clock) begin
      exp_t e;
      logic [31:0] m;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         m = 32'd0;
         m[0] = bus.PCout;   m[1] = bus.Zhighout; m[2] = bus.Zlowout; m[3] = bus.MDRout;
         m[4] = bus.HIout;   m[5] = bus.LOout;    m[6] = bus.PCin;    m[7] = bus.MARin;
         m[8] = bus.MDRin;   m[9] = bus.IRin;     m[10] = bus.Yin;    m[11] = bus.Zin;
         m[12] = bus.HIin;   m[13] = bus.LOin;    m[14] = bus.IncPC;  m[15] = bus.Read;
         m[16] = bus.Write;  m[17] = bus.Gra;     m[18] = bus.Grb;    m[19] = bus.Grc;
         m[20] = bus.Rin;    m[21] = bus.Rout;    m[22] = bus.BAout;  m[23] = bus.Cout;
         checkOutput("state", 32'(bus.Present_state), 32'(e.state));
         checkOutput("strobes", m, e.mask);
         checkOutput("alu_opcode", 32'(bus.opcode), 32'(e.alu));
         checkOutput("run", 32'(bus.Run), 32'(e.run));
      end
   end

   // Watchdog so that a stuck run still ends with a reported failure.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus: directed scenarios first, then random instructions.
   initial begin
      int remaining;
      logic [4:0] op;
      clear = 1'b1;
      bus.Stop = 1'b0;
      bus.IR = 32'h0;
      @(posedge Clock);
      #1;
      applyStimulus(S_RESET, 32'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0);
      applyStimulus(S_RESET, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
      runInstr(5'b00101, 1'b0, -1);
      runInstr(5'b01111, 1'b0, -1);
      runInstr(5'b00010, 1'b0, -1);
      runInstr(5'b11011, 1'b0, -1);
      runInstr(5'b00000, 1'b1, -1);
      runInstr(5'b00011, 1'b0, 4);
      runInstr(5'b11010, 1'b1, -1);
      runInstr(5'b11000, 1'b0, -1);
      runInstr(5'b10001, 1'b0, -1);
      for (int i = 0; i < 200; i++) begin
         op = 5'($urandom_range(0, 31));
         runInstr(op, ($urandom_range(0, 9) == 0), -2);
      end
      remaining = 10;
      while (expQ.size() > 0 && remaining > 0) begin
         @(posedge Clock);
         remaining--;
      end
      @(negedge Clock);
      #1;
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
